// File: rtl/pkt_mem_resp_pkg.sv
// Shared constants and helpers for the packet/table memory responder.
// Bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN (see pkt_mem_resp).
package pkt_mem_resp_pkg;

   localparam int MEM_ADDR_W    = 32;
   localparam int MEM_DATA_W    = 64;
   localparam int MEM_DEPTH     = 4096;
   localparam int MEM_MAX_WIDTH = MEM_DATA_W / 8;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [MEM_ADDR_W-1:0] ZERO_ADDR = {MEM_ADDR_W{1'b0}};
   localparam logic [MEM_DATA_W-1:0] ZERO_WORD = {MEM_DATA_W{1'b0}};

   // Width is legal when it names between one and max_width bytes.
   function automatic logic width_legal(input logic [3:0] width, input logic [4:0] max_width);
      return (width != 4'd0) && ({1'b0, width} <= max_width);
   endfunction

endpackage

// File: rtl/pkt_mem_resp_mem_bank.sv
// Byte-wide RAM with one independent read/write port per byte lane.
// Reads are combinational; the responder registers the assembled word.
module mem_bank
   import pkt_mem_resp_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int LANES = MEM_MAX_WIDTH,
   parameter int IDX_W = $clog2(MEM_DEPTH)
) (
   input  logic                        clk,
   input  logic [LANES-1:0][IDX_W-1:0] i_idx,
   input  logic [LANES-1:0]            i_we,
   input  logic [LANES-1:0][7:0]       i_wdata,
   output logic [LANES-1:0][7:0]       o_rdata
);

   logic [7:0] r_mem [0:DEPTH-1];

   // Lane writes; indices within one access are always distinct.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (i_we[k]) begin
            r_mem[i_idx[k]] <= i_wdata[k];
         end
      end
   end

   // Asynchronous lane reads.
   always_comb begin
      o_rdata = '0;
      for (int k = 0; k < LANES; k++) begin
         o_rdata[k] = r_mem[i_idx[k]];
      end
   end

endmodule

// File: rtl/pkt_mem_resp.sv
// Responder for the proc memory bus plus a byte-wide host port on idle cycles.
// Define MEM_BOUNDS_CHECK_EN to reject accesses past DEPTH instead of wrapping.
module pkt_mem_resp
   import pkt_mem_resp_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_width_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              host_valid_i,
   output logic              host_ready_o,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [7:0]        host_data_i,
   output logic              host_rvalid_o,
   output logic [7:0]        host_data_o,
   output logic              err_o
);

   localparam int         LANES    = DATA_W / 8;
   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [4:0] LANES_W5 = 5'(LANES);

   logic                        w_width_ok;
   logic                        w_bus_in_range;
   logic                        w_host_in_range;
   logic                        w_bus_legal;
   logic                        w_bus_wr;
   logic                        w_bus_rd;
   logic                        w_host_xfer;
   logic                        w_host_rd;
   logic [4:0]                  w_pad_bytes;
   logic [DATA_W-1:0]           w_wdata_aligned;
   logic [DATA_W-1:0]           w_rd_packed;
   logic [DATA_W-1:0]           w_rd_word;
   logic [LANES-1:0][IDX_W-1:0] w_lane_idx;
   logic [LANES-1:0]            w_lane_we;
   logic [LANES-1:0][7:0]       w_lane_wdata;
   logic [LANES-1:0][7:0]       w_lane_rdata;
   logic                        w_unused;

   logic [DATA_W-1:0]           r_mem_data;
   logic                        r_err;
   logic                        r_host_rvalid;
   logic [7:0]                  r_host_data;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   logic [ADDR_W:0] w_bus_last;

   // Last byte computed one bit wider so a wrapping access is still caught.
   assign w_bus_last      = {1'b0, mem_addr_i} + {{(ADDR_W-3){1'b0}}, mem_width_i}
                            - {{ADDR_W{1'b0}}, 1'b1};
   assign w_bus_in_range  = (w_bus_last < DEPTH_EXT);
   assign w_host_in_range = ({1'b0, host_addr_i} < DEPTH_EXT);
`else
   assign w_bus_in_range  = TRUE;
   assign w_host_in_range = TRUE;
`endif

   assign w_unused     = ^{mem_addr_i[ADDR_W-1:IDX_W], host_addr_i[ADDR_W-1:IDX_W]};

   assign w_width_ok   = width_legal(mem_width_i, LANES_W5);
   assign w_bus_legal  = w_width_ok & w_bus_in_range;
   assign w_bus_wr     = mem_ce_i & mem_we_i & w_bus_legal;
   assign w_bus_rd     = mem_ce_i & ~mem_we_i;
   assign host_ready_o = host_valid_i & ~mem_ce_i;
   assign w_host_xfer  = host_ready_o;
   assign w_host_rd    = w_host_xfer & ~host_we_i;

   // Big-endian: left-justify the right-aligned write data so lane k takes byte k from the top.
   assign w_pad_bytes     = w_width_ok ? (LANES_W5 - {1'b0, mem_width_i}) : 5'd0;
   assign w_wdata_aligned = mem_data_i << {w_pad_bytes, 3'b000};

   // Lane address, enable and data; lane 0 is lent to the host when the bus is idle.
   always_comb begin
      w_lane_idx   = '0;
      w_lane_we    = '0;
      w_lane_wdata = '0;
      for (int k = 0; k < LANES; k++) begin
         w_lane_idx[k]   = mem_addr_i[IDX_W-1:0] + IDX_W'(k);
         w_lane_wdata[k] = w_wdata_aligned[8*(LANES-1-k) +: 8];
         w_lane_we[k]    = w_bus_wr & ({1'b0, mem_width_i} > 5'(k));
      end
      if (!mem_ce_i) begin
         w_lane_idx[0]   = host_addr_i[IDX_W-1:0];
         w_lane_wdata[0] = host_data_i;
         w_lane_we[0]    = w_host_xfer & host_we_i & w_host_in_range;
      end else begin
         w_lane_idx[0]   = mem_addr_i[IDX_W-1:0];
      end
   end

   // Gather active lanes MSB-first, then right-align to the access width.
   always_comb begin
      w_rd_packed = '0;
      for (int k = 0; k < LANES; k++) begin
         if ({1'b0, mem_width_i} > 5'(k)) begin
            w_rd_packed[8*(LANES-1-k) +: 8] = w_lane_rdata[k];
         end else begin
            w_rd_packed[8*(LANES-1-k) +: 8] = 8'h00;
         end
      end
      w_rd_word = w_rd_packed >> {w_pad_bytes, 3'b000};
   end

   mem_bank #(
      .DEPTH (DEPTH),
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_mem_bank (
      .clk     (clk),
      .i_idx   (w_lane_idx),
      .i_we    (w_lane_we),
      .i_wdata (w_lane_wdata),
      .o_rdata (w_lane_rdata)
   );

   // Registered responses; read data holds until the next bus or host read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mem_data    <= '0;
         r_err         <= FALSE;
         r_host_rvalid <= FALSE;
         r_host_data   <= 8'h00;
      end else begin
         if (w_bus_rd) begin
            r_mem_data <= w_bus_legal ? w_rd_word : '0;
         end else begin
            r_mem_data <= r_mem_data;
         end
         if (w_host_rd) begin
            r_host_data <= w_host_in_range ? w_lane_rdata[0] : 8'h00;
         end else begin
            r_host_data <= r_host_data;
         end
         r_host_rvalid <= w_host_rd;
         r_err         <= (mem_ce_i & ~w_bus_legal) | (w_host_xfer & ~w_host_in_range);
      end
   end

   assign mem_data_o    = r_mem_data;
   assign err_o         = r_err;
   assign host_rvalid_o = r_host_rvalid;
   assign host_data_o   = r_host_data;

endmodule
